// File: rtl/dense_layer_if.sv
// Handshake and data bundle for the dense (fully connected) layer.
// Carries the feature vector, weight matrix, biases and scored results.
interface dense_layer_if #(
  parameter int FLATTENED_LENGTH = 432,
  parameter int NUM_CLASSES      = 10,
  parameter int DATA_WIDTH       = 8,
  parameter int ACC_WIDTH        = 32
);
  localparam int CW = (NUM_CLASSES > 1) ?
                      $clog2(NUM_CLASSES) : 1;

  logic start;
  logic ready;
  logic done;
  logic signed [DATA_WIDTH-1:0]
    flattened_infmap [FLATTENED_LENGTH];
  logic signed [DATA_WIDTH-1:0]
    weights [NUM_CLASSES][FLATTENED_LENGTH];
  logic signed [ACC_WIDTH-1:0] biases [NUM_CLASSES];
  logic signed [ACC_WIDTH-1:0] scores [NUM_CLASSES];
  logic [CW-1:0] predicted_class;

  modport master (
    output start, flattened_infmap, weights, biases,
    input  ready, done, scores, predicted_class
  );

  modport slave (
    input  start, flattened_infmap, weights, biases,
    output ready, done, scores, predicted_class
  );
endinterface

// File: rtl/dense_layer.sv
// Sequential dense layer: one MAC per cycle over every class,
// bias added on each class's last element, running argmax.
module dense_layer #(
  parameter int FLATTENED_LENGTH = 432,
  parameter int NUM_CLASSES      = 10,
  parameter int DATA_WIDTH       = 8,
  parameter int ACC_WIDTH        = 32
) (
  input logic          clk,
  input logic          reset,
  dense_layer_if.slave bus
);
  localparam int L  = FLATTENED_LENGTH;
  localparam int N  = NUM_CLASSES;
  localparam int IW = (L > 1) ? $clog2(L) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                       state;
  logic [IW-1:0]                idx;
  logic [CW-1:0]                cls;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  best;
  logic signed [DATA_WIDTH-1:0] xl [L];

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    ext;
  logic signed [ACC_WIDTH-1:0]    mac;
  logic signed [ACC_WIDTH-1:0]    sum;
  logic                           last_i;
  logic                           last_c;

  always_comb begin
    prod   = xl[idx] * bus.weights[cls][idx];
    ext    = ACC_WIDTH'(prod);
    mac    = acc + ext;
    sum    = mac + bus.biases[cls];
    last_i = (idx == IW'(L - 1));
    last_c = (cls == CW'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      cls   <= '0;
      acc   <= '0;
      best  <= '0;
      bus.done            <= 1'b0;
      bus.ready           <= 1'b1;
      bus.predicted_class <= '0;
      for (int n = 0; n < N; n++)
        bus.scores[n] <= '0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            xl        <= bus.flattened_infmap;
            acc       <= '0;
            idx       <= '0;
            cls       <= '0;
            bus.ready <= 1'b0;
            state     <= MAC;
          end
        end
        MAC: begin
          if (last_i) begin
            bus.scores[cls] <= sum;
            acc <= '0;
            idx <= '0;
            // class 0 seeds the max; strict > keeps lowest index on ties
            if (cls == '0 || sum > best) begin
              best                <= sum;
              bus.predicted_class <= cls;
            end
            if (last_c)
              state <= DONE;
            else
              cls <= cls + 1'b1;
          end else begin
            acc <= mac;
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          bus.done  <= 1'b1;
          bus.ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
